// File: rtl/rtc_read_scheduler.sv
// rtc_read_scheduler: paces RTC register reads and replays the captured
// time/date bytes to the display block as a 12-cycle inicioSecuencia burst.
// Optional feature macro: BCD_CONV_EN (convert captured packed-BCD bytes to binary).

module rtc_read_scheduler #(
  parameter int         FRAME_DIV = 60,
  parameter logic [3:0] ADDR_BASE = 4'h0,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       update_now,
  output logic       rtc_req,
  output logic [3:0] rtc_addr,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_data,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_SEND} state_t;

  state_t     state, state_nx;
  logic [7:0] frame_cnt;
  logic [2:0] idx, idx_nx;
  logic [7:0] tmo_cnt, tmo_nx;
  logic [3:0] sidx, sidx_nx, sidx_m1;
  logic       pend, pend_nx;
  logic [7:0] rd_buf [8];
  logic       wrap, start, capture;
  logic       req_nx, seq_nx, busy_nx, err_nx;
  logic [3:0] addr_nx;
  logic [7:0] dato_nx;

  assign wrap    = frame_tick && (frame_cnt == FRAME_LAST);
  assign start   = wrap || update_now;
  assign sidx_m1 = sidx_nx - 4'd1;

  function automatic logic [7:0] conv_byte(input logic [7:0] b);
`ifdef BCD_CONV_EN
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9)
      conv_byte = b;
    else
      conv_byte = ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
`else
    conv_byte = b;
`endif
  endfunction

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tmo_nx   = tmo_cnt;
    sidx_nx  = sidx;
    pend_nx  = pend;
    err_nx   = err;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend || start) begin
          state_nx = ST_REQ;
          idx_nx   = 3'd0;
          tmo_nx   = 8'd0;
          pend_nx  = 1'b0;
        end
      end
      ST_REQ: begin
        if (rtc_ack) begin
          capture  = 1'b1;
          state_nx = ST_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nx   = 1'b1;
          tmo_nx   = 8'd0;
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        tmo_nx = 8'd0;
        if (idx == 3'd7) begin
          state_nx = ST_SEND;
          sidx_nx  = 4'd0;
          err_nx   = 1'b0;
        end else begin
          idx_nx   = idx + 3'd1;
          state_nx = ST_REQ;
        end
      end
      ST_SEND: begin
        if (sidx == 4'd11) begin
          sidx_nx  = 4'd0;
          state_nx = ST_IDLE;
        end else begin
          sidx_nx = sidx + 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (state != ST_IDLE && start)
      pend_nx = 1'b1;

    req_nx  = (state_nx == ST_REQ);
    addr_nx = req_nx ? (ADDR_BASE + {1'b0, idx_nx}) : 4'h0;
    seq_nx  = (state_nx == ST_SEND);
    busy_nx = (state_nx != ST_IDLE);
    dato_nx = 8'h00;
    if (seq_nx && sidx_nx >= 4'd1 && sidx_nx <= 4'd8)
      dato_nx = rd_buf[sidx_m1[2:0]];
  end

  // State, sequencing counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      idx             <= 3'd0;
      tmo_cnt         <= 8'd0;
      sidx            <= 4'd0;
      pend            <= 1'b0;
      rtc_req         <= 1'b0;
      rtc_addr        <= 4'h0;
      inicioSecuencia <= 1'b0;
      datoRTC         <= 8'h00;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_nx;
      idx             <= idx_nx;
      tmo_cnt         <= tmo_nx;
      sidx            <= sidx_nx;
      pend            <= pend_nx;
      rtc_req         <= req_nx;
      rtc_addr        <= addr_nx;
      inicioSecuencia <= seq_nx;
      datoRTC         <= dato_nx;
      busy            <= busy_nx;
      err             <= err_nx;
    end
  end

  // Frame divider: runs in every state, wraps on reaching FRAME_DIV
  always_ff @(posedge clk) begin
    if (!reset)
      frame_cnt <= 8'd0;
    else if (frame_tick)
      frame_cnt <= wrap ? 8'd0 : frame_cnt + 8'd1;
  end

  // Capture buffer for the eight RTC registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++)
        rd_buf[i] <= 8'h00;
    end else if (capture) begin
      rd_buf[idx] <= conv_byte(rtc_data);
    end
  end

endmodule

// File: tb/tb_rtc_read_scheduler.sv
// Testbench for rtc_read_scheduler: RTC responder model, burst monitor and
// scenario tasks checked against a behavioural model of the read/replay rules.

module tb_rtc_read_scheduler;

  localparam int FDIV    = 60;
  localparam int TB_BASE = 0;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       update_now = 1'b0;
  logic       rtc_ack = 1'b0;
  logic [7:0] rtc_data = 8'h00;
  logic       rtc_req;
  logic [3:0] rtc_addr;
  logic       inicioSecuencia;
  logic [7:0] datoRTC;
  logic       busy;
  logic       err;

  int total = 0;
  int bad = 0;

  logic [7:0] rtc_mem [16];
  int ack_delay = 2;
  int no_ack_addr = -1;
  bit stray_en = 1'b0;
  int req_age = 0;
  int tick_mod = 0;

  logic [7:0] burst_q [$];
  int addr_log [$];
  int burst_count = 0;
  int req_rises = 0;
  logic prev_seq = 1'b0;
  logic prev_req = 1'b0;

  rtc_read_scheduler #(.FRAME_DIV(FDIV), .ADDR_BASE(4'(TB_BASE)), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .update_now(update_now),
    .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_ack(rtc_ack), .rtc_data(rtc_data),
    .inicioSecuencia(inicioSecuencia), .datoRTC(datoRTC), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // RTC bus model: acks ack_delay cycles into a request, optionally never for one address
  always @(negedge clk) begin
    if (rtc_req) req_age++; else req_age = 0;
    if (rtc_req && req_age == ack_delay && int'(rtc_addr) != no_ack_addr) begin
      rtc_ack  = 1'b1;
      rtc_data = rtc_mem[rtc_addr];
      addr_log.push_back(int'(rtc_addr));
    end else if (stray_en && !rtc_req) begin
      rtc_ack  = 1'($urandom);
      rtc_data = 8'($urandom);
    end else begin
      rtc_ack  = 1'b0;
      rtc_data = 8'($urandom);
    end
  end

  // Monitor: collects burst bytes and counts bursts / request rises
  always @(negedge clk) begin
    if (inicioSecuencia) burst_q.push_back(datoRTC);
    if (inicioSecuencia && !prev_seq) burst_count++;
    if (rtc_req && !prev_req) req_rises++;
    prev_seq = inicioSecuencia;
    prev_req = rtc_req;
  end

  function automatic logic [7:0] model_byte(input logic [7:0] raw);
`ifdef BCD_CONV_EN
    int hi = int'(raw[7:4]);
    int lo = int'(raw[3:0]);
    if (hi > 9 || lo > 9) return raw;
    return 8'(hi * 10 + lo);
`else
    return raw;
`endif
  endfunction

  function automatic logic [7:0] expected_byte(input int k);
    if (k >= 1 && k <= 8) return model_byte(rtc_mem[4'(TB_BASE + k - 1)]);
    return 8'h00;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    tick_mod = (tick_mod + 1) % FDIV;
  endtask

  task automatic pulse_update();
    step();
    update_now = 1'b1;
    step();
    update_now = 1'b0;
  endtask

  task automatic clear_logs();
    burst_q.delete();
    addr_log.delete();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++)
      rtc_mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                 : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endtask

  // Waits from the first request until the burst finishes; reports read phase length
  task automatic collect_sequence(output int read_cycles, output bit ok);
    read_cycles = 0;
    ok = 1'b0;
    while (!inicioSecuencia && read_cycles < 2000) begin
      step();
      read_cycles++;
    end
    if (inicioSecuencia) begin
      for (int i = 0; i < 40; i++) begin
        step();
        if (!inicioSecuencia) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++; if (rtc_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b want=0", rtc_req); end
    total++; if (rtc_addr !== 4'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", rtc_addr); end
    total++; if (inicioSecuencia !== 1'b0) begin bad++; $display("[TB] FAIL reset_inicio got=%b want=0", inicioSecuencia); end
    total++; if (datoRTC !== 8'h00) begin bad++; $display("[TB] FAIL reset_dato got=%h want=00", datoRTC); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
    reset = 1'b1;
    tick_mod = 0;
    begin
      int base = req_rises;
      repeat (FDIV - 1) pulse_frame();
      total++; if (req_rises !== base) begin bad++; $display("[TB] FAIL idle_59_ticks req_rises got=%0d want=%0d", req_rises, base); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_59_busy got=%b want=0", busy); end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] fixed [8] = '{8'h24, 8'h04, 8'h03, 8'h23, 8'h12, 8'h17, 8'h05, 8'h04};
    int rc;
    bit ok;
    logic [7:0] got;
    for (int i = 0; i < 8; i++) rtc_mem[4'(TB_BASE + i)] = fixed[i];
    ack_delay = 2;
    clear_logs();
    pulse_frame();
    total++; if (rtc_req !== 1'b1) begin bad++; $display("[TB] FAIL periodic_first_req got=%b want=1", rtc_req); end
    total++; if (rtc_addr !== 4'(TB_BASE)) begin bad++; $display("[TB] FAIL periodic_first_addr got=%h want=%h", rtc_addr, 4'(TB_BASE)); end
    collect_sequence(rc, ok);
    total++; if (rc !== 24) begin bad++; $display("[TB] FAIL periodic_read_cycles got=%0d want=24", rc); end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL periodic_done got=%b want=1", ok); end
    total++; if (burst_q.size() !== 12) begin bad++; $display("[TB] FAIL periodic_burst_len got=%0d want=12", burst_q.size()); end
    for (int k = 0; k < 12; k++) begin
      got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
      total++; if (got !== expected_byte(k)) begin bad++; $display("[TB] FAIL periodic_byte%0d got=%h want=%h", k, got, expected_byte(k)); end
    end
    for (int k = 0; k < 8; k++) begin
      int a = (k < addr_log.size()) ? addr_log[k] : -1;
      total++; if (a !== (TB_BASE + k) % 16) begin bad++; $display("[TB] FAIL periodic_addr%0d got=%0d want=%0d", k, a, (TB_BASE + k) % 16); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL periodic_err got=%b want=0", err); end
  endtask

  task automatic test_bcd();
    int rc;
    bit ok;
    logic [7:0] got;
    logic [7:0] want59;
`ifdef BCD_CONV_EN
    want59 = 8'd59;
`else
    want59 = 8'h59;
`endif
    randomize_mem();
    rtc_mem[4'(TB_BASE)]     = 8'h59;
    rtc_mem[4'(TB_BASE + 1)] = 8'h3A;
    clear_logs();
    pulse_update();
    collect_sequence(rc, ok);
    got = (burst_q.size() > 1) ? burst_q[1] : 8'hxx;
    total++; if (got !== want59) begin bad++; $display("[TB] FAIL bcd_seconds got=%h want=%h", got, want59); end
    got = (burst_q.size() > 2) ? burst_q[2] : 8'hxx;
    total++; if (got !== 8'h3A) begin bad++; $display("[TB] FAIL bcd_raw_invalid got=%h want=3a", got); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL bcd_err got=%b want=0", err); end
  endtask

  task automatic test_timeout();
    int rc;
    bit ok;
    int stuck = 0;
    int cyc = 0;
    int base_b;
    logic [7:0] got;
    randomize_mem();
    ack_delay = 2;
    no_ack_addr = (TB_BASE + 3) % 16;
    clear_logs();
    base_b = burst_count;
    pulse_update();
    while (busy && cyc < 400) begin
      if (rtc_req && int'(rtc_addr) == no_ack_addr) stuck++;
      step();
      cyc++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_end busy got=%b want=0", busy); end
    total++; if (stuck !== TMO) begin bad++; $display("[TB] FAIL timeout_req_cycles got=%0d want=%0d", stuck, TMO); end
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL timeout_err got=%b want=1", err); end
    total++; if (rtc_req !== 1'b0) begin bad++; $display("[TB] FAIL timeout_req got=%b want=0", rtc_req); end
    total++; if (burst_count !== base_b) begin bad++; $display("[TB] FAIL timeout_no_burst got=%0d want=%0d", burst_count, base_b); end
    total++; if (addr_log.size() !== 3) begin bad++; $display("[TB] FAIL timeout_acks got=%0d want=3", addr_log.size()); end
    // recovery with fresh data; err stays set until the sequence completes
    no_ack_addr = -1;
    randomize_mem();
    clear_logs();
    pulse_update();
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL timeout_err_sticky got=%b want=1", err); end
    collect_sequence(rc, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL recover_done got=%b want=1", ok); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL recover_err got=%b want=0", err); end
    for (int k = 0; k < 12; k++) begin
      got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
      total++; if (got !== expected_byte(k)) begin bad++; $display("[TB] FAIL recover_byte%0d got=%h want=%h", k, got, expected_byte(k)); end
    end
    // ack arriving in the very last allowed cycle still counts as success
    ack_delay = TMO;
    randomize_mem();
    clear_logs();
    pulse_update();
    collect_sequence(rc, ok);
    total++; if (rc !== 8 * (TMO + 1)) begin bad++; $display("[TB] FAIL late_ack_cycles got=%0d want=%0d", rc, 8 * (TMO + 1)); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL late_ack_err got=%b want=0", err); end
    for (int k = 0; k < 12; k++) begin
      got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
      total++; if (got !== expected_byte(k)) begin bad++; $display("[TB] FAIL late_ack_byte%0d got=%h want=%h", k, got, expected_byte(k)); end
    end
    ack_delay = 2;
  endtask

  task automatic test_simultaneous();
    int rc;
    bit ok;
    int base_r, base_b;
    ack_delay = 1;
    randomize_mem();
    base_r = req_rises;
    repeat ((FDIV - 1 - tick_mod + FDIV) % FDIV) pulse_frame();
    total++; if (req_rises !== base_r) begin bad++; $display("[TB] FAIL simul_pre_ticks got=%0d want=%0d", req_rises, base_r); end
    base_b = burst_count;
    step();
    frame_tick = 1'b1;
    update_now = 1'b1;
    step();
    frame_tick = 1'b0;
    update_now = 1'b0;
    tick_mod = 0;
    total++; if (rtc_req !== 1'b1) begin bad++; $display("[TB] FAIL simul_req got=%b want=1", rtc_req); end
    collect_sequence(rc, ok);
    repeat (30) step();
    total++; if (req_rises - base_r !== 8) begin bad++; $display("[TB] FAIL simul_reads got=%0d want=8", req_rises - base_r); end
    total++; if (burst_count - base_b !== 1) begin bad++; $display("[TB] FAIL simul_bursts got=%0d want=1", burst_count - base_b); end
  endtask

  task automatic test_pending();
    int rc;
    bit ok;
    int n = 0;
    int base_b;
    logic [7:0] got;
    ack_delay = 1;
    randomize_mem();
    clear_logs();
    base_b = burst_count;
    pulse_update();
    while (!inicioSecuencia && n < 200) begin step(); n++; end
    step();
    step();
    pulse_update();
    n = 0;
    while (inicioSecuencia && n < 40) begin step(); n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL pend_idle_busy got=%b want=0", busy); end
    total++; if (rtc_req !== 1'b0) begin bad++; $display("[TB] FAIL pend_idle_req got=%b want=0", rtc_req); end
    step();
    total++; if (rtc_req !== 1'b1) begin bad++; $display("[TB] FAIL pend_restart_req got=%b want=1", rtc_req); end
    total++; if (rtc_addr !== 4'(TB_BASE)) begin bad++; $display("[TB] FAIL pend_restart_addr got=%h want=%h", rtc_addr, 4'(TB_BASE)); end
    collect_sequence(rc, ok);
    total++; if (burst_count - base_b !== 2) begin bad++; $display("[TB] FAIL pend_bursts got=%0d want=2", burst_count - base_b); end
    total++; if (burst_q.size() !== 24) begin bad++; $display("[TB] FAIL pend_bytes got=%0d want=24", burst_q.size()); end
    for (int k = 0; k < 24; k++) begin
      got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
      total++; if (got !== expected_byte(k % 12)) begin bad++; $display("[TB] FAIL pend_byte%0d got=%h want=%h", k, got, expected_byte(k % 12)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int rc;
    bit ok;
    int n = 0;
    int base_r;
    logic [7:0] got;
    repeat (30) pulse_frame();
    ack_delay = 1;
    randomize_mem();
    clear_logs();
    pulse_update();
    while (burst_q.size() < 5 && n < 200) begin step(); n++; end
    total++; if (burst_q.size() !== 5) begin bad++; $display("[TB] FAIL midrst_reach got=%0d want=5", burst_q.size()); end
    reset = 1'b0;
    step();
    total++; if (inicioSecuencia !== 1'b0) begin bad++; $display("[TB] FAIL midrst_inicio got=%b want=0", inicioSecuencia); end
    total++; if (datoRTC !== 8'h00) begin bad++; $display("[TB] FAIL midrst_dato got=%h want=00", datoRTC); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    total++; if (rtc_req !== 1'b0) begin bad++; $display("[TB] FAIL midrst_req got=%b want=0", rtc_req); end
    step();
    reset = 1'b1;
    tick_mod = 0;
    total++; if (burst_q.size() !== 5) begin bad++; $display("[TB] FAIL midrst_no_tail got=%0d want=5", burst_q.size()); end
    base_r = req_rises;
    repeat (FDIV - 1) pulse_frame();
    total++; if (req_rises !== base_r) begin bad++; $display("[TB] FAIL midrst_frame_cleared got=%0d want=%0d", req_rises, base_r); end
    clear_logs();
    pulse_frame();
    total++; if (rtc_req !== 1'b1) begin bad++; $display("[TB] FAIL midrst_wrap_req got=%b want=1", rtc_req); end
    collect_sequence(rc, ok);
    for (int k = 0; k < 12; k++) begin
      got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
      total++; if (got !== expected_byte(k)) begin bad++; $display("[TB] FAIL midrst_byte%0d got=%h want=%h", k, got, expected_byte(k)); end
    end
  endtask

  task automatic test_random();
    int rc;
    bit ok;
    logic [7:0] got;
    stray_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      randomize_mem();
      ack_delay = $urandom_range(1, 4);
      clear_logs();
      if ($urandom_range(0, 1) == 0) pulse_update();
      else repeat (FDIV - tick_mod) pulse_frame();
      total++; if (rtc_req !== 1'b1) begin bad++; $display("[TB] FAIL rand%0d_start got=%b want=1", it, rtc_req); end
      collect_sequence(rc, ok);
      total++; if (rc !== 8 * (ack_delay + 1)) begin bad++; $display("[TB] FAIL rand%0d_cycles got=%0d want=%0d", it, rc, 8 * (ack_delay + 1)); end
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rand%0d_done got=%b want=1", it, ok); end
      for (int k = 0; k < 12; k++) begin
        got = (k < burst_q.size()) ? burst_q[k] : 8'hxx;
        total++; if (got !== expected_byte(k)) begin bad++; $display("[TB] FAIL rand%0d_byte%0d got=%h want=%h", it, k, got, expected_byte(k)); end
      end
      for (int k = 0; k < 8; k++) begin
        int a = (k < addr_log.size()) ? addr_log[k] : -1;
        total++; if (a !== (TB_BASE + k) % 16) begin bad++; $display("[TB] FAIL rand%0d_addr%0d got=%0d want=%0d", it, k, a, (TB_BASE + k) % 16); end
      end
      repeat ($urandom_range(1, 5)) step();
    end
    stray_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rtc_mem[i] = 8'h00;
    test_reset();
    test_periodic();
    test_bcd();
    test_timeout();
    test_simultaneous();
    test_pending();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_read_scheduler.md
Name: rtc_read_scheduler

Overview:
- Paces RTC reads and sequences the transfer of time/date registers into the VGA interface block.
- Every FRAME_DIV frame ticks, or on a forced request, reads 8 RTC registers over a req/ack bus into a local buffer.
- Replays the buffer as an inicioSecuencia burst: one preamble cycle, then 8 data cycles, then 3 trailer cycles.
- Sits between the RTC bus master and the Interfaz display block.

Parameters:
- FRAME_DIV, 60, number of frame_tick pulses between automatic reads (1..255).
- ADDR_BASE, 4'h0, RTC address of the first register; reg k is read at ADDR_BASE+k.
- TIMEOUT, 64, cycles to wait for rtc_ack before aborting a read (2..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-cycle pulse at end of each video frame.
- update_now  in  1  one-cycle forced-read request.
- rtc_req  out  1  read request to RTC bus master.
- rtc_addr  out  4  register address, valid while rtc_req=1.
- rtc_ack  in  1  one-cycle pulse; rtc_data valid in the same cycle.
- rtc_data  in  8  read data.
- inicioSecuencia  out  1  high for the whole 12-cycle transfer burst.
- datoRTC  out  8  byte stream to the display block.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky timeout flag; cleared only by reset or the next successful read sequence.

Behaviour:
- Reset (reset=0 at a clk edge) forces IDLE and sets all outputs to 0. It also clears frame_cnt, idx, tmo_cnt, pend and the 8-byte buffer.
- Reset applied mid-read or mid-burst aborts the operation immediately; no partial burst continues.
- frame_cnt (8 bit):
  - Increments on each frame_tick.
  - On the tick that makes it reach FRAME_DIV, it wraps to 0 and raises a start event.
  - It counts in every state.
- Start events are a frame_cnt wrap or update_now.
  - In IDLE, a start event moves to REQ on the next edge.
  - Otherwise it sets pend (1-bit; extra events while pend=1 are dropped).
  - Simultaneous wrap and update_now produce a single start.
- State machine:
  - IDLE:
    - If pend=1, go to REQ and clear pend.
    - If a start event occurs, go to REQ.
    - idx=0 on entry to REQ from IDLE.
  - REQ:
    - rtc_req=1, rtc_addr=ADDR_BASE+idx (4-bit wrap). tmo_cnt increments each cycle.
    - On rtc_ack: buf[idx]<=rtc_data (optionally converted), rtc_req drops next cycle, go to GAP.
    - If tmo_cnt reaches TIMEOUT-1 without ack: err<=1, rtc_req<=0, go to IDLE. The buffer keeps its old contents and no burst is sent.
  - GAP:
    - One cycle with rtc_req=0, tmo_cnt<=0.
    - If idx=7, go to SEND with sidx=0 and err<=0; else idx<=idx+1 and return to REQ.
  - SEND:
    - 12 cycles with inicioSecuencia=1.
    - sidx=0: datoRTC=8'h00 (preamble).
    - sidx=1..8: datoRTC=buf[sidx-1]. Byte order is seconds, minutes, hours, date, month, year, day, week.
    - sidx=9..11: datoRTC=8'h00.
    - After sidx=11: inicioSecuencia<=0 and go to IDLE.
- Output registration: all outputs are registered, so datoRTC and inicioSecuencia change on the same edge.
- rtc_ack outside REQ is ignored.
- An ack in the same cycle that the timeout expires counts as success; ack has priority.
- Latency:
  - From the start event to the first rtc_req is 1 cycle.
  - With ack returned 1 cycle after req, the 8 reads take 8×(2+1)=24 cycles.
  - The SEND burst begins on the edge after the final GAP.

Optional Feature:
- BCD_CONV_EN
  - Defined: each captured byte is converted from packed BCD to binary, value = hi×10 + lo. A byte with either nibble >9 is stored raw and does not set err.
  - Undefined: bytes are stored exactly as read.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release. All outputs are 0, busy=0, and no rtc_req appears for 59 frame_ticks.
- Periodic read, FRAME_DIV=60:
  - Stimulus: 60 frame_ticks; RTC ack returns 24,4,3,23,12,17,5,4 (hex 0x24 etc. with conversion).
  - Required response: rtc_addr steps 0..7, then a 12-cycle inicioSecuencia burst with datoRTC = 00,24,4,3,23,12,17,5,4,00,00,00.
- BCD_CONV_EN defined: RTC returns 8'h59 for seconds -> datoRTC cycle 1 = 8'd59. Undefined -> 8'h59.
- Timeout: no ack at addr 3 -> after 64 cycles err=1, rtc_req=0, no burst. The next fully acked sequence clears err and the burst carries the new data.
- Simultaneous/pending events:
  - update_now together with a frame_cnt wrap in IDLE -> exactly one sequence.
  - update_now during SEND -> pend=1, and a second sequence starts 1 cycle after IDLE is reached.
- Reset mid-burst: reset=0 at sidx=4 -> next cycle inicioSecuencia=0, datoRTC=0, buffer cleared, state IDLE.
